// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the MIPS memory arbiter: FSM state encoding, grant
// identifiers and a small address helper.
package mips_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Bus transfers are whole words; the two low address bits must be zero.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mips_mem_arb_select.sv
// Combinational grant selection between the fetch (I) and load/store (D)
// requesters.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When defined, a tie goes
// to the port that did not win last time; otherwise D always beats I.
module mips_mem_arb_select
  import mips_mem_arbiter_pkg::*;
(
  input  logic   i_elig_i,
  input  logic   d_elig_i,
  input  grant_t last_grant_i,
  output logic   grant_valid_o,
  output grant_t grant_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores the grant history; keep it visibly consumed.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // Pick a winner among the eligible ports; the tie rule is build-dependent.
  always_comb begin
    grant_valid_o = i_elig_i | d_elig_i;
    grant_o       = GRANT_I;
    if (i_elig_i && d_elig_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_o = (last_grant_i == GRANT_I) ? GRANT_D : GRANT_I;
`else
      grant_o = GRANT_D;
`endif
    end else if (d_elig_i) begin
      grant_o = GRANT_D;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the core's single Avalon-MM master between instruction fetch (I,
// read-only) and load/store (D). All bus outputs are registered and held
// across waitrequest; read data is captured into per-port registers.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break,
// implemented in mips_mem_arb_select).
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  // instruction-fetch port
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_done,
  output logic [DW-1:0]   i_rdata,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            busy,
  // Avalon-MM master
  output logic [AW-1:0]   address,
  output logic            read,
  output logic            write,
  output logic [DW-1:0]   writedata,
  output logic [DW/8-1:0] byteenable,
  input  logic            waitrequest,
  input  logic [DW-1:0]   readdata
);

  localparam int BW = DW / 8;

  arb_state_t    state_q, state_d;
  grant_t        last_grant_q, last_grant_d;
  logic [AW-1:0] address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [DW-1:0] writedata_q, writedata_d;
  logic [BW-1:0] byteenable_q, byteenable_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic   i_elig, d_elig;
  logic   grant_valid;
  grant_t grant;

  // A port whose done is pulsing right now is still holding its old request;
  // masking it stops the same access from being issued twice.
  assign i_elig = i_req & ~i_done_q;
  assign d_elig = d_req & ~d_done_q;

  mips_mem_arb_select u_select (
    .i_elig_i      (i_elig),
    .d_elig_i      (d_elig),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: launch from idle on a grant, return to idle when the slave
  // stops stalling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d = (grant == GRANT_D) ? ARB_D : ARB_I;
        end
      end
      ARB_I, ARB_D: begin
        if (!waitrequest) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless this
  // cycle launches or completes a transfer.
  always_comb begin
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant;
          if (grant == GRANT_D) begin
            address_d    = d_addr;
            read_d       = ~d_we;
            write_d      = d_we;
            writedata_d  = d_wdata;
            byteenable_d = d_be;
          end else begin
            address_d    = i_addr;
            read_d       = 1'b1;
            write_d      = 1'b0;
            byteenable_d = '1;
          end
        end
      end
      ARB_I: begin
        if (!waitrequest) begin
          read_d    = 1'b0;
          i_rdata_d = readdata;
          i_done_d  = 1'b1;
        end
      end
      ARB_D: begin
        if (!waitrequest) begin
          // Writes leave the last read word untouched.
          if (read_q) begin
            d_rdata_d = readdata;
          end
          read_d   = 1'b0;
          write_d  = 1'b0;
          d_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset drops the bus immediately and clears all data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      last_grant_q <= GRANT_I;
    end else begin
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign i_done     = i_done_q;
  assign d_done     = d_done_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = (state_q != ARB_IDLE);

`ifndef SYNTHESIS
  a_no_rw_overlap: assert property (@(posedge clk) disable iff (reset)
    !(read_q && write_q));
  a_word_aligned: assert property (@(posedge clk) disable iff (reset)
    (state_q != ARB_IDLE) |-> is_word_aligned(address_q[1:0]));
  a_i_req_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == ARB_I) |-> i_req);
  a_d_req_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == ARB_D) |-> d_req);
`endif

endmodule
